uart8_stream_bridge: RTL and testbench

Buffered user-side front end for the 8-bit UART core: converts valid/ready byte streams into the core's start/busy/done transmit and receive handshakes, with one FIFO per direction. Sits in the board-clock domain between application logic and the UART core's rx/tx ports. It never touches the serial line directly.

---
 rtl/uart8_stream_bridge_if.sv | 21 ++
 rtl/uart8_stream_bridge.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart8_stream_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart8_stream_bridge_if.sv
// User-side byte streams of the UART bridge: transmit (s*) into the bridge,
// receive (m*) out of the bridge with its frame-error flag.
interface uart8_stream_bridge_if;
    logic       sValid;
    logic       sReady;
    logic [7:0] sData;
    logic       mValid;
    logic       mReady;
    logic [7:0] mData;
    logic       mErr;

    modport slave (
        input  sValid, sData, mReady,
        output sReady, mValid, mData, mErr
    );

    modport master (
        output sValid, sData, mReady,
        input  sReady, mValid, mData, mErr
    );
endinterface

// File: rtl/uart8_stream_bridge.sv
// Buffered front end for the 8-bit UART core: TX FIFO feeding a start/busy
// sequencer, RX done-edge capture into a show-ahead FIFO with sticky overflow.
module uart8_stream_bridge #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    uart8_stream_bridge_if.slave      user,
    output logic [$clog2(TX_DEPTH):0] txCount,
    output logic [$clog2(RX_DEPTH):0] rxCount,
    output logic                      rxOverflow,
    input  logic                      ovfClr,
    output logic                      uartTxEn,
    output logic                      uartRxEn,
    output logic                      uartTxStart,
    output logic [7:0]                uartTxIn,
    input  logic                      uartTxBusy,
    input  logic                      uartTxDone,
    input  logic                      uartRxBusy,
    input  logic                      uartRxDone,
    input  logic                      uartRxErr,
    input  logic [7:0]                uartRxOut
);
    localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW  = TX_AW + 1;
    localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW  = RX_AW + 1;
    localparam int unsigned SYNC_W = 13;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rxEntry_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } txState_t;

    // ------------------------------------------------------------------
    // Core status synchronizers (the core runs on derived clocks)
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0] syncMeta;
    logic [SYNC_W-1:0] syncQ;
    logic              txBusyS;
    logic              txDoneS;
    logic              rxBusyS;
    logic              rxDoneS;
    logic              rxErrS;
    logic [7:0]        rxOutS;
    logic              unusedStatus;

    always_ff @(posedge clk) begin
        if (!reset) begin
            syncMeta <= '0;
            syncQ    <= '0;
        end else begin
            syncMeta <= {uartTxBusy, uartTxDone, uartRxBusy, uartRxDone, uartRxErr, uartRxOut};
            syncQ    <= syncMeta;
        end
    end

    assign {txBusyS, txDoneS, rxBusyS, rxDoneS, rxErrS, rxOutS} = syncQ;

    // Transmit completion is tracked through busy alone; these are not needed.
    assign unusedStatus = txDoneS ^ rxBusyS;

    always_ff @(posedge clk) begin
        if (!reset) begin
            uartTxEn <= 1'b0;
            uartRxEn <= 1'b0;
        end else begin
            uartTxEn <= en;
            uartRxEn <= en;
        end
    end

    // Block new starts after reset until the synchronized busy is seen low,
    // so a frame abandoned in the core is not mistaken for an acknowledge.
    logic [1:0] syncFill;
    logic       txHoldOff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            syncFill  <= 2'b00;
            txHoldOff <= 1'b1;
        end else begin
            syncFill <= {syncFill[0], 1'b1};
            if (syncFill[1] && !txBusyS) begin
                txHoldOff <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       txMem [TX_DEPTH];
    logic [TX_AW-1:0] txWrPtr;
    logic [TX_AW-1:0] txRdPtr;
    logic [TX_CW-1:0] txCountNext;
    logic             txPush;
    logic             txPop;
    logic             txPending;
    txState_t         txState;

    assign txPush      = user.sValid && user.sReady;
    assign txPop       = (txState == TX_IDLE) && uartTxEn && txPending
                         && (txCount != '0) && !txHoldOff;
    assign txCountNext = txCount + TX_CW'(txPush) - TX_CW'(txPop);

    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[txWrPtr] <= user.sData;
        end
    end

    // txPending lags occupancy by one cycle: a written byte is launchable the
    // cycle after it lands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            txWrPtr     <= '0;
            txRdPtr     <= '0;
            txCount     <= '0;
            txPending   <= 1'b0;
            user.sReady <= 1'b0;
        end else begin
            if (txPush) begin
                txWrPtr <= txWrPtr + TX_AW'(1);
            end
            if (txPop) begin
                txRdPtr <= txRdPtr + TX_AW'(1);
            end
            txCount     <= txCountNext;
            txPending   <= (txCount != '0);
            user.sReady <= (txCountNext != TX_CW'(TX_DEPTH));
        end
    end

    // Start/busy sequencer toward the core transmitter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            txState     <= TX_IDLE;
            uartTxStart <= 1'b0;
            uartTxIn    <= 8'h00;
        end else begin
            case (txState)
                TX_IDLE: begin
                    if (txPop) begin
                        uartTxIn    <= txMem[txRdPtr];
                        uartTxStart <= 1'b1;
                        txState     <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (txBusyS) begin
                        uartTxStart <= 1'b0;
                        txState     <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (!txBusyS) begin
                        txState <= TX_IDLE;
                    end
                end
                default: begin
                    uartTxStart <= 1'b0;
                    txState     <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX capture: one entry per synchronized done rising edge
    // ------------------------------------------------------------------
    logic     rxDonePrev;
    logic     rxPushPend;
    rxEntry_t rxPend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxDonePrev <= 1'b0;
            rxPushPend <= 1'b0;
            rxPend     <= '0;
        end else begin
            rxDonePrev <= rxDoneS;
            rxPushPend <= rxDoneS && !rxDonePrev;
            if (rxDoneS && !rxDonePrev) begin
                rxPend <= '{err: rxErrS, data: rxOutS};
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO, show-ahead with registered head
    // ------------------------------------------------------------------
    rxEntry_t         rxMem [RX_DEPTH];
    logic [RX_AW-1:0] rxWrPtr;
    logic [RX_AW-1:0] rxRdPtr;
    logic [RX_AW-1:0] rxRdPtrNext;
    logic [RX_CW-1:0] rxCountNext;
    logic [RX_CW-1:0] rxCountAfterPop;
    logic             rxFull;
    logic             rxPush;
    logic             rxDrop;
    logic             rxPop;
    rxEntry_t         rxHeadNext;

    assign rxFull          = (rxCount == RX_CW'(RX_DEPTH));
    assign rxPush          = rxPushPend && !rxFull;
    assign rxDrop          = rxPushPend && rxFull;
    assign rxPop           = user.mValid && user.mReady;
    assign rxRdPtrNext     = rxRdPtr + RX_AW'(rxPop);
    assign rxCountAfterPop = rxCount - RX_CW'(rxPop);
    assign rxCountNext     = rxCountAfterPop + RX_CW'(rxPush);

    // An entry pushed into an empty (or just-emptied) FIFO is the next head.
    assign rxHeadNext = (rxCountAfterPop == '0) ? rxPend : rxMem[rxRdPtrNext];

    always_ff @(posedge clk) begin
        if (rxPush) begin
            rxMem[rxWrPtr] <= rxPend;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxWrPtr     <= '0;
            rxRdPtr     <= '0;
            rxCount     <= '0;
            user.mValid <= 1'b0;
            user.mData  <= 8'h00;
            user.mErr   <= 1'b0;
        end else begin
            if (rxPush) begin
                rxWrPtr <= rxWrPtr + RX_AW'(1);
            end
            rxRdPtr     <= rxRdPtrNext;
            rxCount     <= rxCountNext;
            user.mValid <= (rxCountNext != '0);
            user.mData  <= rxHeadNext.data;
            user.mErr   <= rxHeadNext.err;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxOverflow <= 1'b0;
        end else if (rxDrop) begin
            rxOverflow <= 1'b1;
        end else if (ovfClr) begin
            rxOverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart8_stream_bridge.sv
// Directed and randomized checks of uart8_stream_bridge against a queue-based
// model of both FIFOs and a behavioural UART core transmitter.
module tb_uart8_stream_bridge;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FRAME = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       ovfClr;
    logic [4:0] txCount;
    logic [4:0] rxCount;
    logic       rxOverflow;
    logic       uartTxEn;
    logic       uartRxEn;
    logic       uartTxStart;
    logic [7:0] uartTxIn;
    logic       uartTxBusy;
    logic       uartTxDone;
    logic       uartRxBusy;
    logic       uartRxDone;
    logic       uartRxErr;
    logic [7:0] uartRxOut;

    uart8_stream_bridge_if user();

    uart8_stream_bridge #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .user        (user),
        .txCount     (txCount),
        .rxCount     (rxCount),
        .rxOverflow  (rxOverflow),
        .ovfClr      (ovfClr),
        .uartTxEn    (uartTxEn),
        .uartRxEn    (uartRxEn),
        .uartTxStart (uartTxStart),
        .uartTxIn    (uartTxIn),
        .uartTxBusy  (uartTxBusy),
        .uartTxDone  (uartTxDone),
        .uartRxBusy  (uartRxBusy),
        .uartRxDone  (uartRxDone),
        .uartRxErr   (uartRxErr),
        .uartRxOut   (uartRxOut)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    bit         coreStall = 1'b0;
    bit         coreOff = 1'b0;
    logic [7:0] txSeen [$];
    logic [7:0] txExp [$];
    logic [8:0] rxExp [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: capture on start, busy for a frame (or while stalled), pulse done.
    initial begin : txCore
        uartTxBusy = 1'b0;
        uartTxDone = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!coreOff && uartTxStart === 1'b1) begin
                txSeen.push_back(uartTxIn);
                uartTxBusy = 1'b1;
                while (coreStall) @(posedge clk);
                repeat (FRAME) @(posedge clk);
                #2;
                uartTxBusy = 1'b0;
                uartTxDone = 1'b1;
                @(posedge clk);
                #2;
                uartTxDone = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic pushByte(input logic [7:0] b, input int budget, output bit ok);
        bit rdy;
        ok = 1'b0;
        user.sValid = 1'b1;
        user.sData  = b;
        for (int i = 0; i < budget && !ok; i++) begin
            rdy = user.sReady;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        user.sValid = 1'b0;
    endtask

    task automatic waitTxSeen(input int n, input int budget, input string tag);
        int c = 0;
        while (txSeen.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(tag, 32'(txSeen.size()), 32'(n));
    endtask

    task automatic rxDeliver(input logic [7:0] v, input logic e);
        uartRxOut  = v;
        uartRxErr  = e;
        uartRxDone = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        uartRxDone = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin : stim
        bit         ok;
        int         accepted;
        int         n;
        int         starts;
        logic [7:0] v;
        logic       e;
        logic [8:0] ent;
        logic [7:0] rxv [2];
        logic       rxe [2];

        reset = 1'b0; en = 1'b0; ovfClr = 1'b0;
        user.sValid = 1'b0; user.sData = 8'h00; user.mReady = 1'b0;
        uartRxDone = 1'b0; uartRxErr = 1'b0; uartRxOut = 8'h00; uartRxBusy = 1'b0;

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst.txCount", 32'(txCount), 32'd0);
        check("rst.rxCount", 32'(rxCount), 32'd0);
        check("rst.mValid", 32'(user.mValid), 32'd0);
        check("rst.sReady", 32'(user.sReady), 32'd0);
        check("rst.rxOverflow", 32'(rxOverflow), 32'd0);
        check("rst.start", 32'(uartTxStart), 32'd0);
        check("rst.txIn", 32'(uartTxIn), 32'd0);
        check("rst.txEn", 32'(uartTxEn), 32'd0);
        check("rst.rxEn", 32'(uartRxEn), 32'd0);
        reset = 1'b1;
        en    = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("run.sReady", 32'(user.sReady), 32'd1);
        check("run.txEn", 32'(uartTxEn), 32'd1);
        check("run.rxEn", 32'(uartRxEn), 32'd1);

        // Single byte: start two edges after acceptance, held until busy
        txSeen.delete();
        user.sValid = 1'b1;
        user.sData  = 8'hA5;
        @(posedge clk); #1;
        user.sValid = 1'b0;
        check("single.txCount", 32'(txCount), 32'd1);
        check("single.startN", 32'(uartTxStart), 32'd0);
        @(posedge clk); #1;
        check("single.startN1", 32'(uartTxStart), 32'd0);
        @(posedge clk); #1;
        check("single.startN2", 32'(uartTxStart), 32'd1);
        check("single.txIn", 32'(uartTxIn), 32'hA5);
        n = 0;
        while (uartTxStart === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            if (uartTxStart === 1'b1) check("single.txInHeld", 32'(uartTxIn), 32'hA5);
            n++;
        end
        check("single.startDrop", 32'(uartTxStart), 32'd0);
        check("single.busyAtDrop", 32'(uartTxBusy), 32'd1);
        waitTxSeen(1, 20, "single.seen");
        if (txSeen.size() > 0) check("single.byte", 32'(txSeen[0]), 32'hA5);
        check("single.txCountEnd", 32'(txCount), 32'd0);

        // Random transmit stream with random gaps
        repeat (20) begin @(posedge clk); #1; end
        txSeen.delete();
        txExp.delete();
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom_range(0, 255));
            pushByte(v, 200, ok);
            if (ok) txExp.push_back(v);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        check("rand.accepted", 32'(txExp.size()), 32'd8);
        waitTxSeen(8, 400, "rand.seen");
        for (int i = 0; i < txExp.size() && i < txSeen.size(); i++)
            check($sformatf("rand.byte%0d", i), 32'(txSeen[i]), 32'(txExp[i]));
        check("rand.txCount", 32'(txCount), 32'd0);

        // TX full with the core stalled
        repeat (20) begin @(posedge clk); #1; end
        txSeen.delete();
        txExp.delete();
        coreStall = 1'b1;
        accepted  = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            pushByte(8'(i), 4, ok);
            if (ok) begin
                txExp.push_back(8'(i));
                accepted++;
            end
        end
        check("full.accepted", 32'(accepted), 32'(DEPTH + 1));
        check("full.txCount", 32'(txCount), 32'(DEPTH));
        check("full.sReady", 32'(user.sReady), 32'd0);
        coreStall = 1'b0;
        waitTxSeen(accepted, accepted * 30, "full.seen");
        for (int i = 0; i < txExp.size() && i < txSeen.size(); i++)
            check($sformatf("full.byte%0d", i), 32'(txSeen[i]), 32'(txExp[i]));

        // RX stream: mValid three edges after done is first sampled
        rxv[0] = 8'h3C; rxe[0] = 1'b0;
        rxv[1] = 8'hC3; rxe[1] = 1'b1;
        user.mReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            uartRxOut  = rxv[k];
            uartRxErr  = rxe[k];
            uartRxDone = 1'b1;
            @(posedge clk); #1;
            check("rxlat.N", 32'(user.mValid), 32'd0);
            @(posedge clk); #1;
            check("rxlat.N1", 32'(user.mValid), 32'd0);
            @(posedge clk); #1;
            check("rxlat.N2", 32'(user.mValid), 32'd0);
            @(posedge clk); #1;
            uartRxDone = 1'b0;
            check("rxlat.N3", 32'(user.mValid), 32'd1);
            check("rxlat.data", 32'(user.mData), 32'(rxv[k]));
            check("rxlat.err", 32'(user.mErr), 32'(rxe[k]));
            repeat (4) begin @(posedge clk); #1; end
            check("rxlat.drained", 32'(rxCount), 32'd0);
        end
        user.mReady = 1'b0;

        // RX overflow with random payloads
        rxExp.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            v = 8'($urandom_range(0, 255));
            e = 1'($urandom_range(0, 1));
            if (rxExp.size() < DEPTH) rxExp.push_back({e, v});
            rxDeliver(v, e);
        end
        repeat (5) begin @(posedge clk); #1; end
        check("ovf.rxCount", 32'(rxCount), 32'(DEPTH));
        check("ovf.flag", 32'(rxOverflow), 32'd1);
        ovfClr = 1'b1;
        @(posedge clk); #1;
        ovfClr = 1'b0;
        check("ovf.cleared", 32'(rxOverflow), 32'd0);

        // Drop and clear on the same edge: the set wins
        uartRxOut  = 8'h77;
        uartRxErr  = 1'b0;
        uartRxDone = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        uartRxDone = 1'b0;
        ovfClr     = 1'b1;
        @(posedge clk); #1;
        ovfClr = 1'b0;
        check("ovf.setWins", 32'(rxOverflow), 32'd1);
        check("ovf.countKept", 32'(rxCount), 32'(DEPTH));
        ovfClr = 1'b1;
        @(posedge clk); #1;
        ovfClr = 1'b0;
        check("ovf.cleared2", 32'(rxOverflow), 32'd0);
        while (rxExp.size() > 0) begin
            ent = rxExp.pop_front();
            check("drain.valid", 32'(user.mValid), 32'd1);
            check("drain.data", 32'(user.mData), 32'(ent[7:0]));
            check("drain.err", 32'(user.mErr), 32'(ent[8]));
            user.mReady = 1'b1;
            @(posedge clk); #1;
            user.mReady = 1'b0;
        end
        check("drain.rxCount", 32'(rxCount), 32'd0);
        check("drain.mValid", 32'(user.mValid), 32'd0);

        // Pop and push on the same edge with one entry held
        rxDeliver(8'h11, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("simul.pre", 32'(rxCount), 32'd1);
        uartRxOut  = 8'h9E;
        uartRxErr  = 1'b1;
        uartRxDone = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        uartRxDone  = 1'b0;
        user.mReady = 1'b1;
        check("simul.oldHead", 32'(user.mData), 32'h11);
        @(posedge clk); #1;
        user.mReady = 1'b0;
        check("simul.rxCount", 32'(rxCount), 32'd1);
        check("simul.newHead", 32'(user.mData), 32'h9E);
        check("simul.newErr", 32'(user.mErr), 32'd1);
        user.mReady = 1'b1;
        @(posedge clk); #1;
        user.mReady = 1'b0;

        // Reset while the sequencer waits for busy with five bytes queued
        repeat (30) begin @(posedge clk); #1; end
        coreOff = 1'b1;
        for (int i = 0; i < 6; i++) pushByte(8'(8'h50 + i), 10, ok);
        repeat (3) begin @(posedge clk); #1; end
        check("rstmid.start", 32'(uartTxStart), 32'd1);
        check("rstmid.txCount", 32'(txCount), 32'd5);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstmid.startDrop", 32'(uartTxStart), 32'd0);
        check("rstmid.txCount0", 32'(txCount), 32'd0);
        check("rstmid.sReady0", 32'(user.sReady), 32'd0);
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rstmid.sReady1", 32'(user.sReady), 32'd1);
        starts = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (uartTxStart === 1'b1) starts++;
        end
        check("rstmid.noStart", 32'(starts), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
